seq_arith_unit: RTL
===================

// Module: seq_arith_unit
// PURPOSE
//  Parametrised, multi-cycle successor to the combinational 8-bit add/sub/mul/div DUTs.
//  - One shared datapath executes one operation per transaction: add, sub, mul or unsigned div.
//  - Ready/valid handshake on input; single-cycle valid pulse on output.
//  - Full-width mul result, div remainder, carry/borrow and divide-by-zero flags.
//  - Sits between a command source (bench, or later a sequencer) and a result consumer.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//  clock           in   1        single clock; everything updates on posedge
//  reset           in   1        synchronous, active-high
//  i_valid         in   1        operands/op presented this cycle
//  o_ready         out  1        unit idle, can accept; accept = i_valid & o_ready
//  i_op            in   2        00 add, 01 sub, 10 mul, 11 div
//  i_value_a       in   WIDTH    operand A (dividend), unsigned
//  i_value_b       in   WIDTH    operand B (divisor), unsigned
//  o_valid         out  1        one-cycle pulse: results below are new
//  o_result        out  WIDTH    sum / difference / product low half / quotient
//  o_result_hi     out  WIDTH    0 / 0 / product high half / remainder
//  o_carry         out  1        add carry-out; sub borrow (A<B); 0 for mul/div
//  o_div_by_zero   out  1        div with B==0; 0 otherwise
// BEHAVIOUR
//  - Reset (sync, active-high): state IDLE, o_ready=1, o_valid=0, all result/flag outputs 0.
//    Reset mid-operation aborts with no o_valid; o_ready=1 in the cycle after reset deasserts.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE: o_ready=1. On accept, latch op/A/B.
//      - add/sub, or div with B==0: go to DONE.
//      - mul/div otherwise: go to RUN with iteration counter = WIDTH-1.
//    - RUN: o_ready=0. One shift-add (mul) or restoring shift-subtract (div) step per cycle.
//      Exactly WIDTH steps; counter==0 -> DONE.
//    - DONE: o_ready=0. Write result registers; o_valid=1 for this cycle only. Next state IDLE.
//  - Latency from accept edge to o_valid high:
//    - 1 cycle: add, sub, div-by-zero.
//    - WIDTH+1 cycles: mul, div.
//  - Throughput: one transaction per 2 cycles (add/sub); one per WIDTH+2 cycles (mul/div).
//  - i_valid while o_ready=0 is ignored; the source must hold the request until accepted.
//  - Results and flags hold their values until the next DONE. o_valid is the only strobe.
//  - Width rules:
//    - add: {o_carry,o_result} = A+B (WIDTH+1 bits).
//    - sub: o_result = (A-B) mod 2^WIDTH, o_carry = (A<B).
//    - mul: {o_result_hi,o_result} = A*B (2*WIDTH bits, exact).
//    - div: o_result = A/B, o_result_hi = A%B.
//  - Divide by zero: o_result = all ones, o_result_hi = A, o_div_by_zero = 1, o_carry = 0.
//  - Simultaneous: in DONE, o_ready=0, so no accept can coincide with o_valid.
// STRUCTURE
//  - Package arith_pkg holds:
//    - op localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
//    - state encoding ST_IDLE, ST_RUN, ST_DONE
//  - Sub-module iter_muldiv_core (WIDTH):
//    - owns the 2*WIDTH accumulator/remainder shift register and the step counter
//    - ports: start, op_is_div, a, b, step_en, done, lo, hi
//  - Top level holds the FSM, the handshake, add/sub logic and the output registers.
// TESTING  (WIDTH=8 unless noted)
//  1. a=20,b=10 each op -> add 30/c0; sub 10/c0; mul lo 200 hi 0; div q 2 r 0.
//     o_valid latency 1,1,9,9 cycles.
//  2. add 200+100 -> 44,c=1. sub 10-20 -> 246,c=1. mul 255*255 -> lo 0x01,hi 0xFE.
//  3. div 7/0 -> o_result 255, o_result_hi 7, o_div_by_zero 1, o_valid 1 cycle after accept.
//  4. div 200/7 with i_valid held high during RUN and i_value_a changed ->
//     single o_valid; q 28 r 4 from the original operands.
//  5. reset asserted on 4th RUN cycle of mul -> no o_valid; outputs 0; o_ready=1 next cycle;
//     new add 1+1 -> 2.
//  6. WIDTH=16, mul 0xFFFF*0xFFFF -> hi 0xFFFE, lo 0x0001, latency 17; div 65535/255 -> q 257 r 0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared operation codes and FSM state encoding for the sequential arithmetic unit.
package arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/iter_muldiv_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one step per enabled cycle.
// lo/hi present the register contents after this cycle's step, so the final step can be captured directly.
module iter_muldiv_core #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step_en,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] step_acc;

  always_comb begin
    // multiply: {carry, partial product, remaining multiplier bits} shifted right each step
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) mul_sum = mul_sum + {1'b0, b_q};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // divide: remainder in the high half, quotient bits shift in at the bottom
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_trial = div_shift[WIDTH-1:0] - b_q;
    div_next  = {(div_ge ? div_trial : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    step_acc = div_q ? div_next : mul_next;
  end

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = {{WIDTH{1'b0}}, a};
      b_d   = b;
      div_d = op_is_div;
      cnt_d = CW'(WIDTH - 1);
    end else if (step_en) begin
      acc_d = step_acc;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
  assign lo   = step_acc[WIDTH-1:0];
  assign hi   = step_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/mul/div unit with ready/valid input and single-cycle result strobe.
// state   | meaning
// IDLE    | o_ready=1, waiting for a request
// RUN     | iterative mul/div in progress, one step per cycle
// DONE    | results registered, o_valid=1 for this cycle
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_value_a,
  input  logic [WIDTH-1:0] i_value_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_carry,
  output logic             o_div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             carry_q, carry_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             core_start;
  logic             core_step;
  logic             core_done;
  logic [WIDTH-1:0] core_lo, core_hi;
  logic [WIDTH:0]   add_sum;

  assign accept  = i_valid && (state_q == ST_IDLE);
  assign add_sum = {1'b0, i_value_a} + {1'b0, i_value_b};

  iter_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (core_start),
    .op_is_div (i_op == OP_DIV),
    .a         (i_value_a),
    .b         (i_value_b),
    .step_en   (core_step),
    .done      (core_done),
    .lo        (core_lo),
    .hi        (core_hi)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    dbz_d       = dbz_q;
    core_start  = 1'b0;
    core_step   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_DONE;
          result_hi_d = '0;
          carry_d     = 1'b0;
          dbz_d       = 1'b0;
          unique case (i_op)
            OP_ADD: begin
              result_d = add_sum[WIDTH-1:0];
              carry_d  = add_sum[WIDTH];
            end
            OP_SUB: begin
              result_d = i_value_a - i_value_b;
              carry_d  = (i_value_a < i_value_b);
            end
            default: begin
              if (i_op == OP_DIV && i_value_b == '0) begin
                result_d    = '1;
                result_hi_d = i_value_a;
                dbz_d       = 1'b1;
              end else begin
                // results stay untouched until the iteration completes
                result_hi_d = result_hi_q;
                carry_d     = carry_q;
                dbz_d       = dbz_q;
                core_start  = 1'b1;
                state_d     = ST_RUN;
              end
            end
          endcase
        end
      end
      ST_RUN: begin
        core_step = 1'b1;
        if (core_done) begin
          result_d    = core_lo;
          result_hi_d = core_hi;
          carry_d     = 1'b0;
          dbz_d       = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      dbz_q       <= dbz_d;
    end
  end

  assign o_ready       = (state_q == ST_IDLE);
  assign o_valid       = (state_q == ST_DONE);
  assign o_result      = result_q;
  assign o_result_hi   = result_hi_q;
  assign o_carry       = carry_q;
  assign o_div_by_zero = dbz_q;

endmodule
